// File: rtl/uninasoc_plic_core_if.sv
// Register-bus request/response bundle between the AXI-to-reg bridge and the PLIC core.
interface uninasoc_plic_core_if #(
  parameter int unsigned AddrWidth = 32
);
  logic                 reg_valid;
  logic                 reg_write;
  logic [AddrWidth-1:0] reg_addr;
  logic [31:0]          reg_wdata;
  logic [3:0]           reg_wstrb;
  logic                 reg_ready;
  logic [31:0]          reg_rdata;
  logic                 reg_error;

  modport master (output reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb,
                  input  reg_ready, reg_rdata, reg_error);
  modport slave  (input  reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb,
                  output reg_ready, reg_rdata, reg_error);
endinterface

// File: rtl/uninasoc_plic_core.sv
// PLIC core on a native reg bus: level/edge gateways, priorities, per-target enables and
// thresholds, claim/complete and msip, with a registered two-cycle bus response.
module uninasoc_plic_core #(
  parameter int unsigned       NumSrc        = 32,
  parameter int unsigned       NumTarget     = 2,
  parameter int unsigned       PrioWidth     = 3,
  parameter logic [NumSrc-1:0] LevelEdgeTrig = '0,
  parameter int unsigned       AddrWidth     = 32,
  localparam int unsigned      SRCW          = $clog2(NumSrc)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  uninasoc_plic_core_if.slave       reg_bus,
  input  logic [NumSrc-1:0]         intr_src_i,
  output logic [NumTarget-1:0]      irq_o,
  output logic [NumTarget*SRCW-1:0] irq_id_o,
  output logic [NumTarget-1:0]      msip_o
);

  localparam int unsigned NumWords = (NumSrc + 31) / 32;
  localparam int unsigned PadW     = NumWords * 32;

  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e               state_q, state_d;
  logic [PrioWidth-1:0] prio_q [NumSrc];
  logic [PrioWidth-1:0] prio_d [NumSrc];
  logic [NumSrc-1:0]    ie_q   [NumTarget];
  logic [NumSrc-1:0]    ie_d   [NumTarget];
  logic [PrioWidth-1:0] thr_q  [NumTarget];
  logic [PrioWidth-1:0] thr_d  [NumTarget];
  logic [SRCW-1:0]      id_q   [NumTarget];
  logic [SRCW-1:0]      id_d   [NumTarget];
  logic [NumTarget-1:0] msip_q, msip_d, irq_q, irq_d;
  logic [NumSrc-1:0]    pending_q, pending_d, insvc_q, insvc_d, src_q;
  logic [NumSrc-1:0]    claim_mask, complete_mask;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [AddrWidth-1:0] addr;
  logic                 wr;
  logic                 in_prio, in_pend, in_en, in_ctx, in_msip;
  logic [31:0]          word_idx, en_tgt, en_word, ctx_tgt, msip_tgt;
  logic [SRCW-1:0]      cpl_id;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    return res;
  endfunction

  // Region decode; the context block excludes the msip window at 0x300000.
  assign addr     = reg_bus.reg_addr;
  assign wr       = reg_bus.reg_write;
  assign in_prio  = addr[AddrWidth-1:12] == '0;
  assign in_pend  = addr[AddrWidth-1:12] == (AddrWidth-12)'(1);
  assign in_en    = addr[AddrWidth-1:12] == (AddrWidth-12)'(2);
  assign in_ctx   = addr[AddrWidth-1:20] == (AddrWidth-20)'(2);
  assign in_msip  = addr[AddrWidth-1:20] == (AddrWidth-20)'(3);
  assign word_idx = 32'(addr[11:2]);
  assign en_tgt   = 32'(addr[11:7]);
  assign en_word  = 32'(addr[6:2]);
  assign ctx_tgt  = 32'(addr[19:12]);
  assign msip_tgt = 32'(addr[19:2]);
  assign cpl_id   = reg_bus.reg_wdata[SRCW-1:0];

  // Bus FSM: all decode, register writes and claim side-effects happen in the IDLE cycle.
  always_comb begin
    logic [PadW-1:0] pad;
    pad           = '0;
    state_d       = state_q;
    prio_d        = prio_q;
    ie_d          = ie_q;
    thr_d         = thr_q;
    msip_d        = msip_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    claim_mask    = '0;
    complete_mask = '0;
    unique case (state_q)
      S_IDLE: begin
        if (reg_bus.reg_valid) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
          if (addr[1:0] == 2'b00) begin
            if (in_prio && word_idx < NumSrc) begin
              err_d = 1'b0;
              for (int i = 1; i < NumSrc; i++) begin
                if (word_idx == 32'(i)) begin
                  rdata_d = 32'(prio_q[i]);
                  if (wr) prio_d[i] = PrioWidth'(apply_strb(32'(prio_q[i]), reg_bus.reg_wdata,
                                                            reg_bus.reg_wstrb));
                end
              end
            end else if (in_pend && word_idx < NumWords && !wr) begin
              err_d = 1'b0;
              pad   = PadW'(pending_q);
              for (int k = 0; k < NumWords; k++)
                if (word_idx == 32'(k)) rdata_d = pad[k*32 +: 32];
            end else if (in_en && en_tgt < NumTarget && en_word < NumWords) begin
              err_d = 1'b0;
              for (int t = 0; t < NumTarget; t++) begin
                for (int k = 0; k < NumWords; k++) begin
                  if (en_tgt == 32'(t) && en_word == 32'(k)) begin
                    pad     = PadW'(ie_q[t]);
                    rdata_d = pad[k*32 +: 32];
                    pad[k*32 +: 32] = apply_strb(pad[k*32 +: 32], reg_bus.reg_wdata,
                                                 reg_bus.reg_wstrb);
                    if (wr) ie_d[t] = NumSrc'(pad) & ~NumSrc'(1);
                  end
                end
              end
            end else if (in_ctx && ctx_tgt < NumTarget &&
                         (addr[11:0] == 12'h000 || addr[11:0] == 12'h004)) begin
              err_d = 1'b0;
              for (int t = 0; t < NumTarget; t++) begin
                if (ctx_tgt == 32'(t)) begin
                  if (addr[2] == 1'b0) begin
                    rdata_d = 32'(thr_q[t]);
                    if (wr) thr_d[t] = PrioWidth'(apply_strb(32'(thr_q[t]), reg_bus.reg_wdata,
                                                             reg_bus.reg_wstrb));
                  end else if (!wr) begin
                    rdata_d = 32'(id_q[t]);
                    for (int i = 1; i < NumSrc; i++)
                      if (id_q[t] == SRCW'(i)) claim_mask[i] = 1'b1;
                  end else if (reg_bus.reg_wstrb != 4'h0) begin
                    for (int i = 1; i < NumSrc; i++)
                      if (cpl_id == SRCW'(i)) complete_mask[i] = 1'b1;
                  end
                end
              end
            end else if (in_msip && msip_tgt < NumTarget) begin
              err_d = 1'b0;
              for (int t = 0; t < NumTarget; t++) begin
                if (msip_tgt == 32'(t)) begin
                  rdata_d = 32'(msip_q[t]);
                  if (wr && reg_bus.reg_wstrb[0]) msip_d[t] = reg_bus.reg_wdata[0];
                end
              end
            end
          end
          if (err_d) rdata_d = '0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Gateways: a claim in the same cycle wins over a new trigger of that source.
  always_comb begin
    logic [NumSrc-1:0] trig;
    trig = '0;
    for (int i = 0; i < NumSrc; i++)
      trig[i] = LevelEdgeTrig[i] ? (intr_src_i[i] & ~src_q[i]) : intr_src_i[i];
    trig      = trig & ~insvc_q & ~claim_mask & ~NumSrc'(1);
    pending_d = (pending_q | trig) & ~claim_mask;
    insvc_d   = (insvc_q | claim_mask) & ~complete_mask;
  end

  // Arbitration: highest priority above threshold, strict compare keeps the lowest ID on ties.
  always_comb begin
    logic [PrioWidth-1:0] best;
    best  = '0;
    irq_d = '0;
    id_d  = '{default: '0};
    for (int t = 0; t < NumTarget; t++) begin
      best = '0;
      for (int i = 1; i < NumSrc; i++) begin
        if (pending_q[i] && ie_q[t][i] && prio_q[i] > thr_q[t] && prio_q[i] > best) begin
          best    = prio_q[i];
          id_d[t] = SRCW'(i);
        end
      end
      irq_d[t] = id_d[t] != '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      prio_q    <= '{default: '0};
      ie_q      <= '{default: '0};
      thr_q     <= '{default: '0};
      id_q      <= '{default: '0};
      msip_q    <= '0;
      irq_q     <= '0;
      pending_q <= '0;
      insvc_q   <= '0;
      src_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      ie_q      <= ie_d;
      thr_q     <= thr_d;
      id_q      <= id_d;
      msip_q    <= msip_d;
      irq_q     <= irq_d;
      pending_q <= pending_d;
      insvc_q   <= insvc_d;
      src_q     <= intr_src_i;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    irq_id_o = '0;
    for (int t = 0; t < NumTarget; t++) irq_id_o[t*SRCW +: SRCW] = id_q[t];
  end

  assign reg_bus.reg_ready = (state_q == S_RESP);
  assign reg_bus.reg_rdata = rdata_q;
  assign reg_bus.reg_error = err_q;
  assign irq_o             = irq_q;
  assign msip_o            = msip_q;

endmodule

// File: tb/tb_uninasoc_plic_core.sv
// Directed self-checking bench for uninasoc_plic_core: gateways, arbitration, claim/complete,
// bus errors and asynchronous reset.
module tb_uninasoc_plic_core;
  localparam int unsigned NumSrc    = 32;
  localparam int unsigned NumTarget = 2;
  localparam int unsigned PrioWidth = 3;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned SRCW      = 5;

  logic                      clk = 1'b0;
  logic                      rst_ni;
  logic [NumSrc-1:0]         intr_src;
  logic [NumTarget-1:0]      irq;
  logic [NumTarget*SRCW-1:0] irq_id;
  logic [NumTarget-1:0]      msip;
  int                        n_checks = 0;
  int                        n_errors = 0;
  logic [31:0]               rd;
  logic                      er;
  int                        ready_cnt;

  uninasoc_plic_core_if #(.AddrWidth(AddrWidth)) bus ();

  uninasoc_plic_core #(
    .NumSrc(NumSrc), .NumTarget(NumTarget), .PrioWidth(PrioWidth),
    .LevelEdgeTrig(32'h0000_0020), .AddrWidth(AddrWidth)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .reg_bus(bus), .intr_src_i(intr_src),
    .irq_o(irq), .irq_id_o(irq_id), .msip_o(msip)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus access; returns two idle cycles after the response so registered IDs settle.
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdata, output logic err);
    logic seen;
    seen  = 1'b0;
    rdata = '0;
    err   = 1'b1;
    bus.reg_valid = 1'b1; bus.reg_write = w; bus.reg_addr = a;
    bus.reg_wdata = d;    bus.reg_wstrb = s;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.reg_ready) begin
        seen  = 1'b1;
        rdata = bus.reg_rdata;
        err   = bus.reg_error;
      end
    end
    bus.reg_valid = 1'b0;
    check_eq("bus ready", 32'(seen), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    logic e;
    bus_xfer(1'b1, a, d, 4'hF, dummy, e);
    check_eq("wr error", 32'(e), 32'd0);
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
    logic e;
    bus_xfer(1'b0, a, 32'd0, 4'h0, d, e);
    check_eq("rd error", 32'(e), 32'd0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    intr_src = '0;
    bus.reg_valid = 1'b0; bus.reg_write = 1'b0; bus.reg_addr = '0;
    bus.reg_wdata = '0;   bus.reg_wstrb = '0;
    wait_cyc(3);
    check_eq("rst ready", 32'(bus.reg_ready), 32'd0);
    check_eq("rst irq", 32'(irq), 32'd0);
    check_eq("rst id", 32'(irq_id), 32'd0);
    check_eq("rst msip", 32'(msip), 32'd0);
    @(negedge clk) rst_ni = 1'b1;
    wait_cyc(1);

    // T1 level source
    reg_wr(32'h0000_000C, 32'd2);
    reg_wr(32'h0000_2000, 32'h8);
    reg_wr(32'h0020_0000, 32'd1);
    intr_src[3] = 1'b1;
    wait_cyc(2);
    check_eq("t1 irq", 32'(irq[0]), 32'd1);
    check_eq("t1 id", 32'(irq_id[4:0]), 32'd3);
    reg_rd(32'h0020_0004, rd);
    check_eq("t1 claim", rd, 32'd3);
    check_eq("t1 irq after claim", 32'(irq[0]), 32'd0);
    intr_src[3] = 1'b0;
    reg_wr(32'h0020_0004, 32'd3);
    wait_cyc(3);
    check_eq("t1 irq after complete", 32'(irq[0]), 32'd0);
    reg_rd(32'h0000_1000, rd);
    check_eq("t1 pending", rd, 32'd0);

    // T2 edge source, second pulse while pending is dropped
    reg_wr(32'h0000_0014, 32'd3);
    reg_wr(32'h0000_2000, 32'h28);
    intr_src[5] = 1'b1; wait_cyc(1); intr_src[5] = 1'b0;
    wait_cyc(2);
    check_eq("t2 irq", 32'(irq[0]), 32'd1);
    check_eq("t2 id", 32'(irq_id[4:0]), 32'd5);
    reg_rd(32'h0000_1000, rd);
    check_eq("t2 pending", rd, 32'h20);
    intr_src[5] = 1'b1; wait_cyc(1); intr_src[5] = 1'b0;
    wait_cyc(2);
    reg_rd(32'h0020_0004, rd);
    check_eq("t2 claim1", rd, 32'd5);
    reg_rd(32'h0020_0004, rd);
    check_eq("t2 claim2", rd, 32'd0);
    check_eq("t2 irq after claim", 32'(irq[0]), 32'd0);
    reg_wr(32'h0020_0004, 32'd5);

    // T3 arbitration order and threshold masking
    reg_wr(32'h0000_0010, 32'd2);
    reg_wr(32'h0000_001C, 32'd5);
    reg_wr(32'h0000_0024, 32'd5);
    reg_wr(32'h0000_2000, 32'h290);
    reg_wr(32'h0020_0000, 32'd0);
    intr_src[4] = 1'b1; intr_src[7] = 1'b1; intr_src[9] = 1'b1;
    wait_cyc(3);
    check_eq("t3 id", 32'(irq_id[4:0]), 32'd7);
    reg_rd(32'h0020_0004, rd);
    check_eq("t3 claim a", rd, 32'd7);
    reg_rd(32'h0020_0004, rd);
    check_eq("t3 claim b", rd, 32'd9);
    reg_rd(32'h0020_0004, rd);
    check_eq("t3 claim c", rd, 32'd4);
    check_eq("t3 irq drained", 32'(irq[0]), 32'd0);
    reg_wr(32'h0020_0004, 32'd7);
    reg_wr(32'h0020_0004, 32'd9);
    wait_cyc(3);
    check_eq("t3 repend irq", 32'(irq[0]), 32'd1);
    check_eq("t3 repend id", 32'(irq_id[4:0]), 32'd7);
    reg_wr(32'h0020_0000, 32'd5);
    wait_cyc(3);
    check_eq("t3 thr irq", 32'(irq[0]), 32'd0);
    check_eq("t3 thr id", 32'(irq_id[4:0]), 32'd0);
    reg_rd(32'h0000_1000, rd);
    check_eq("t3 pending", rd, 32'h280);
    intr_src[4] = 1'b0; intr_src[7] = 1'b0; intr_src[9] = 1'b0;

    // T4 two targets share source 6
    reg_wr(32'h0000_0018, 32'd7);
    reg_wr(32'h0000_2000, 32'h2D0);
    reg_wr(32'h0000_2080, 32'h40);
    intr_src[6] = 1'b1;
    wait_cyc(3);
    check_eq("t4 irq both", 32'(irq), 32'd3);
    check_eq("t4 id t0", 32'(irq_id[4:0]), 32'd6);
    check_eq("t4 id t1", 32'(irq_id[9:5]), 32'd6);
    reg_rd(32'h0020_1004, rd);
    check_eq("t4 claim t1", rd, 32'd6);
    check_eq("t4 irq dropped", 32'(irq), 32'd0);
    reg_wr(32'h0020_1004, 32'd6);
    wait_cyc(3);
    check_eq("t4 irq reassert", 32'(irq), 32'd3);
    check_eq("t4 id t1 again", 32'(irq_id[9:5]), 32'd6);

    // T5 bus errors leave state untouched; strobes, reserved ID 0, msip
    bus_xfer(1'b0, 32'h0000_1002, 32'd0, 4'h0, rd, er);
    check_eq("t5 misaligned err", 32'(er), 32'd1);
    check_eq("t5 misaligned rdata", rd, 32'd0);
    bus_xfer(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, rd, er);
    check_eq("t5 pending wr err", 32'(er), 32'd1);
    bus_xfer(1'b0, 32'h0020_2000, 32'd0, 4'h0, rd, er);
    check_eq("t5 bad target err", 32'(er), 32'd1);
    check_eq("t5 irq unchanged", 32'(irq), 32'd3);
    reg_rd(32'h0000_1000, rd);
    check_eq("t5 pending unchanged", rd, 32'h2C0);
    bus_xfer(1'b1, 32'h0000_0018, 32'd0, 4'b0010, rd, er);
    reg_rd(32'h0000_0018, rd);
    check_eq("t5 strobe prio6", rd, 32'd7);
    reg_wr(32'h0000_0000, 32'd7);
    reg_rd(32'h0000_0000, rd);
    check_eq("t5 prio0", rd, 32'd0);
    reg_rd(32'h0020_0000, rd);
    check_eq("t5 thr0", rd, 32'd5);
    reg_wr(32'h0030_0004, 32'd1);
    check_eq("t5 msip", 32'(msip), 32'h2);
    reg_rd(32'h0030_0004, rd);
    check_eq("t5 msip rd", rd, 32'd1);

    // T6 asynchronous reset during the response cycle
    bus.reg_valid = 1'b1; bus.reg_write = 1'b0; bus.reg_addr = 32'h0020_0000;
    wait_cyc(1);
    check_eq("t6 in resp", 32'(bus.reg_ready), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_eq("t6 ready", 32'(bus.reg_ready), 32'd0);
    check_eq("t6 irq", 32'(irq), 32'd0);
    check_eq("t6 id", 32'(irq_id), 32'd0);
    check_eq("t6 msip", 32'(msip), 32'd0);
    check_eq("t6 rdata", bus.reg_rdata, 32'd0);
    bus.reg_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    ready_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.reg_ready) ready_cnt++;
    end
    check_eq("t6 no ready", 32'(ready_cnt), 32'd0);
    check_eq("t6 irq after", 32'(irq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
